// File: rtl/stack_mem_engine.sv
// Moves data between the operand stack and data memory: push-constant, burst LOAD/STORE and
// stack-addressed LOADI/STOREI, with one command in flight at a time and full/empty abort.
module stack_mem_engine #(
    parameter int ADDR_LEN = 8,
    parameter int DATA_LEN = 8,
    parameter int CNT_LEN  = 3
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                en,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [2:0]          cmd_op,
    input  logic [ADDR_LEN-1:0] cmd_addr,
    input  logic [DATA_LEN-1:0] cmd_imm,
    input  logic [CNT_LEN-1:0]  cmd_len,
    output logic                done,
    output logic                err,
    output logic                stk_push,
    output logic                stk_pop,
    output logic [DATA_LEN-1:0] stk_data_in,
    input  logic [DATA_LEN-1:0] stk_data_out,
    input  logic                stk_full,
    input  logic                stk_empty,
    output logic                mem_r_en,
    output logic                mem_w_en,
    output logic [ADDR_LEN-1:0] mem_addr,
    output logic [DATA_LEN-1:0] mem_data_in,
    input  logic [DATA_LEN-1:0] mem_data_out
);

    localparam logic [2:0] OP_NOP    = 3'b000;
    localparam logic [2:0] OP_PUSHC  = 3'b001;
    localparam logic [2:0] OP_LOAD   = 3'b010;
    localparam logic [2:0] OP_STORE  = 3'b011;
    localparam logic [2:0] OP_LOADI  = 3'b100;
    localparam logic [2:0] OP_STOREI = 3'b101;

    typedef enum logic [3:0] {
        S_IDLE, S_PUSH, S_RD, S_WAIT, S_POPD, S_POPA, S_WR, S_DONE, S_ERR
    } state_t;

    state_t              r_state, w_next;
    logic [2:0]          r_op, w_op;
    logic [ADDR_LEN-1:0] r_base, w_base, w_maddr;
    logic [DATA_LEN-1:0] r_data, w_data;
    logic [CNT_LEN-1:0]  r_len, w_len, r_idx, w_idx;
    logic                r_abort, w_abort;

    logic                r_ready, r_done, r_err, r_push, r_pop, r_rd, r_wr;
    logic [ADDR_LEN-1:0] r_maddr;
    logic [DATA_LEN-1:0] r_sdin, r_mdin;

    always_comb begin
        w_next  = r_state;
        w_op    = r_op;
        w_base  = r_base;
        w_data  = r_data;
        w_len   = r_len;
        w_idx   = r_idx;
        w_abort = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid && r_ready) begin
                    w_op   = cmd_op;
                    w_base = cmd_addr;
                    w_data = cmd_imm;
                    w_len  = cmd_len;
                    w_idx  = '0;
                    case (cmd_op)
                        OP_NOP:   w_next = S_DONE;
                        OP_PUSHC: begin w_next = S_PUSH; w_abort = stk_full;  end
                        OP_LOAD:  w_next = S_RD;
                        OP_STORE: begin w_next = S_POPD; w_abort = stk_empty; end
                        OP_LOADI, OP_STOREI: begin
                            w_next  = S_POPA;
                            w_abort = stk_empty;
                        end
                        default:  w_next = S_ERR;
                    endcase
                end
            end
            // An aborted strobe state still occupies its cycle with the strobe suppressed.
            S_PUSH: begin
                if (r_abort) begin
                    w_next = S_ERR;
                end else if (r_op == OP_LOAD && r_idx != r_len) begin
                    w_idx  = r_idx + 1'b1;
                    w_next = S_RD;
                end else begin
                    w_next = S_DONE;
                end
            end
            S_RD: w_next = S_WAIT;
            S_WAIT: begin
                w_data  = mem_data_out;
                w_next  = S_PUSH;
                w_abort = stk_full;
            end
            S_POPA: begin
                if (r_abort) begin
                    w_next = S_ERR;
                end else begin
                    w_base = stk_data_out[ADDR_LEN-1:0];
                    if (r_op == OP_LOADI) begin
                        w_next = S_RD;
                    end else begin
                        w_next  = S_POPD;
                        w_abort = stk_empty;
                    end
                end
            end
            S_POPD: begin
                if (r_abort) begin
                    w_next = S_ERR;
                end else begin
                    w_data = stk_data_out;
                    w_next = S_WR;
                end
            end
            S_WR: begin
                if (r_op == OP_STORE && r_idx != r_len) begin
                    w_idx   = r_idx + 1'b1;
                    w_next  = S_POPD;
                    w_abort = stk_empty;
                end else begin
                    w_next = S_DONE;
                end
            end
            S_DONE, S_ERR: w_next = S_IDLE;
            default:       w_next = S_IDLE;
        endcase
        w_maddr = w_base + ADDR_LEN'(w_idx);
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            r_op    <= '0;
            r_base  <= '0;
            r_data  <= '0;
            r_len   <= '0;
            r_idx   <= '0;
            r_abort <= 1'b0;
            r_ready <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_push  <= 1'b0;
            r_pop   <= 1'b0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_maddr <= '0;
            r_sdin  <= '0;
            r_mdin  <= '0;
        end else begin
            r_state <= w_next;
            r_op    <= w_op;
            r_base  <= w_base;
            r_data  <= w_data;
            r_len   <= w_len;
            r_idx   <= w_idx;
            r_abort <= w_abort;
            r_ready <= (w_next == S_IDLE) && en;
            r_done  <= (w_next == S_DONE) || (w_next == S_ERR);
            r_err   <= (w_next == S_ERR);
            r_push  <= (w_next == S_PUSH) && !w_abort;
            r_pop   <= ((w_next == S_POPA) || (w_next == S_POPD)) && !w_abort;
            r_rd    <= (w_next == S_RD);
            r_wr    <= (w_next == S_WR);
            if (w_next == S_RD || w_next == S_WR) r_maddr <= w_maddr;
            if (w_next == S_PUSH) r_sdin <= w_data;
            if (w_next == S_WR)   r_mdin <= w_data;
        end
    end

    assign cmd_ready   = r_ready;
    assign done        = r_done;
    assign err         = r_err;
    assign stk_push    = r_push;
    assign stk_pop     = r_pop;
    assign stk_data_in = r_sdin;
    assign mem_r_en    = r_rd;
    assign mem_w_en    = r_wr;
    assign mem_addr    = r_maddr;
    assign mem_data_in = r_mdin;

endmodule
